// File: rtl/data_cache_if.sv
// CPU-side and memory-side bus of the data cache.
// slave is the cache's view; master is the view of whatever drives the CPU
// request and answers the memory request.
interface data_cache_if #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4
);
    logic                            cpu_read;
    logic                            cpu_write;
    logic [WORD_SIZE-1:0]            cpu_address;
    logic [WORD_SIZE-1:0]            cpu_wdata;
    logic [WORD_SIZE-1:0]            cpu_rdata;
    logic                            cpu_ready;
    logic                            mem_read;
    logic                            mem_write;
    logic [WORD_SIZE-1:0]            mem_address;
    logic [WORD_SIZE-1:0]            mem_wdata;
    logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata;
    logic                            mem_ack;

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// CPU's MEM-stage data port and the backing data memory. Read hits finish
// in the request cycle; misses fill a whole line, writes go straight through
// and only update the cached copy when the line is already present.
// Load hits and misses are counted.
module data_cache #(
    parameter int WORD_SIZE   = 16,
    parameter int INDEX_BITS  = 2,
    parameter int OFFSET_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,   // active-high synchronous reset
    data_cache_if.slave          bus,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam logic [WORD_SIZE-1:0] CNT_ONE = WORD_SIZE'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                               state_r;
    logic [LINES-1:0]                     valid_r;
    logic [TAG_BITS-1:0]                  tag_r  [LINES];
    logic [WORDS-1:0][WORD_SIZE-1:0]      line_r [LINES];
    logic                                 filled_r;

    logic [OFFSET_BITS-1:0]               offset_s;
    logic [INDEX_BITS-1:0]                index_s;
    logic [TAG_BITS-1:0]                  tag_s;
    logic                                 hit_s;
    logic                                 read_hit_s;
    logic [WORD_SIZE-1:0]                 word_s;

    assign offset_s   = bus.cpu_address[OFFSET_BITS-1:0];
    assign index_s    = bus.cpu_address[OFFSET_BITS +: INDEX_BITS];
    assign tag_s      = bus.cpu_address[WORD_SIZE-1 -: TAG_BITS];
    assign hit_s      = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign word_s     = line_r[index_s][offset_s];
    // A simultaneous write wins, so a read only completes when no write is pending.
    assign read_hit_s = bus.cpu_read && !bus.cpu_write && hit_s;

    // Per-state bus outputs; read hits answer in the same cycle.
    always_comb begin
        bus.cpu_ready   = 1'b0;
        bus.cpu_rdata   = {WORD_SIZE{1'b0}};
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = {WORD_SIZE{1'b0}};
        bus.mem_wdata   = {WORD_SIZE{1'b0}};
        case (state_r)
            IDLE: begin
                if (read_hit_s) begin
                    bus.cpu_ready = 1'b1;
                    bus.cpu_rdata = word_s;
                end else begin
                    bus.cpu_ready = 1'b0;
                end
            end
            FILL: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = {tag_s, index_s, {OFFSET_BITS{1'b0}}};
            end
            WRITE: begin
                bus.mem_write   = 1'b1;
                bus.mem_address = bus.cpu_address;
                bus.mem_wdata   = bus.cpu_wdata;
                bus.cpu_ready   = bus.mem_ack;
            end
            default: begin
                bus.cpu_ready = 1'b0;
            end
        endcase
    end

    // Controller FSM, line storage and hit/miss counters.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_r    <= IDLE;
            valid_r    <= {LINES{1'b0}};
            filled_r   <= 1'b0;
            hit_count  <= {WORD_SIZE{1'b0}};
            miss_count <= {WORD_SIZE{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // The first IDLE cycle after a fill is the refill completing,
                    // not a fresh hit; the flag only lives for that one cycle.
                    filled_r <= 1'b0;
                    if (bus.cpu_write) begin
                        state_r <= WRITE;
                    end else if (bus.cpu_read) begin
                        if (hit_s) begin
                            if (!filled_r) begin
                                hit_count <= hit_count + CNT_ONE;
                            end
                        end else begin
                            miss_count <= miss_count + CNT_ONE;
                            state_r    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        line_r[index_s]  <= bus.mem_rdata;
                        tag_r[index_s]   <= tag_s;
                        valid_r[index_s] <= 1'b1;
                        filled_r         <= 1'b1;
                        state_r          <= IDLE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        // No allocation on a write miss; only a present line is patched.
                        if (hit_s) begin
                            line_r[index_s][offset_s] <= bus.cpu_wdata;
                        end
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a behavioural backing memory answers
// fills and write-throughs, load data goes through a scoreboard queue, and
// each scenario task checks stall length, memory requests and counters.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    data_cache_if bus ();

    data_cache dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] sb_exp;
    logic [15:0] model [65536];
    int          ack_delay = 0;
    bit          resp_en   = 1'b0;
    logic        resp_ack  = 1'b0;
    logic        manual_ack = 1'b0;
    int          wait_cnt  = 0;

    assign bus.mem_ack = resp_en ? resp_ack : manual_ack;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    // Backing memory: ack after ack_delay cycles of a held request.
    always @(posedge clk) begin
        #1;
        if (!resp_en) begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end else if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
            if (wait_cnt == ack_delay) begin
                resp_ack = 1'b1;
                wait_cnt = 0;
                if (bus.mem_read === 1'b1) begin
                    for (int w = 0; w < 4; w++)
                        bus.mem_rdata[w*16 +: 16] = model[int'(bus.mem_address) + w];
                end else begin
                    model[int'(bus.mem_address)] = bus.mem_wdata;
                end
            end else begin
                resp_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Scoreboard: every completed load is compared with the queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b0 && bus.cpu_ready === 1'b1 &&
            bus.cpu_read === 1'b1 && bus.cpu_write === 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: load completed addr=%h rdata=%h, required no completion",
                         bus.cpu_address, bus.cpu_rdata);
            end else begin
                sb_exp = exp_q.pop_front();
                if (bus.cpu_rdata !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_rdata: addr=%h got %h required %h",
                             bus.cpu_address, bus.cpu_rdata, sb_exp);
                end
            end
        end
    end

    task automatic do_read(input logic [15:0] a, input logic [15:0] e,
                           output int stall, output bit saw_rd, output logic [15:0] fa);
        stall = 0; saw_rd = 1'b0; fa = 16'h0000;
        bus.cpu_read = 1'b1; bus.cpu_address = a;
        exp_q.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_read === 1'b1 && !saw_rd) begin saw_rd = 1'b1; fa = bus.mem_address; end
            if (bus.cpu_ready === 1'b1) break;
            stall++;
        end
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, output int stall,
                            output bit saw_wr, output logic [15:0] wa, output logic [15:0] wd);
        stall = 0; saw_wr = 1'b0; wa = 16'h0000; wd = 16'h0000;
        bus.cpu_write = 1'b1; bus.cpu_address = a; bus.cpu_wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_write === 1'b1 && !saw_wr) begin
                saw_wr = 1'b1; wa = bus.mem_address; wd = bus.mem_wdata;
            end
            if (bus.cpu_ready === 1'b1) break;
            stall++;
        end
        @(posedge clk); #1;
        bus.cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; resp_en = 1'b1; manual_ack = 1'b0;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_address = 16'h0000; bus.cpu_wdata = 16'h0000; bus.mem_rdata = 64'h0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b required 0", bus.cpu_ready); end
        total++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL rst_memreq: got rd=%b wr=%b required 0 0", bus.mem_read, bus.mem_write); end
        total++; if (bus.mem_address !== 16'h0000 || bus.cpu_rdata !== 16'h0000 || bus.mem_wdata !== 16'h0000) begin bad++; $display("FAIL rst_data: got addr=%h rdata=%h wdata=%h required 0", bus.mem_address, bus.cpu_rdata, bus.mem_wdata); end
        total++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin bad++; $display("FAIL rst_counters: got hit=%0d miss=%0d required 0 0", hit_count, miss_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss();
        int st; bit rd; logic [15:0] fa;
        ack_delay = 3;
        do_read(16'h0013, pat(16'h0013), st, rd, fa);
        total++; if (!rd || fa !== 16'h0010) begin bad++; $display("FAIL miss_fill_addr: got req=%b addr=%h required 1 0010", rd, fa); end
        total++; if (st != 5) begin bad++; $display("FAIL miss_stall: got %0d required 5", st); end
        total++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin bad++; $display("FAIL miss_counters: got hit=%0d miss=%0d required 0 1", hit_count, miss_count); end
    endtask

    task automatic test_read_hits();
        int st; bit rd; logic [15:0] fa;
        do_read(16'h0011, pat(16'h0011), st, rd, fa);
        total++; if (st != 0 || rd) begin bad++; $display("FAIL hit1: got stall=%0d memread=%b required 0 0", st, rd); end
        do_read(16'h0012, pat(16'h0012), st, rd, fa);
        total++; if (st != 0 || rd) begin bad++; $display("FAIL hit2: got stall=%0d memread=%b required 0 0", st, rd); end
        total++; if (hit_count !== 16'd2) begin bad++; $display("FAIL hit_count: got %0d required 2", hit_count); end
    endtask

    task automatic test_write_hit();
        int st; bit wr; bit rd; logic [15:0] wa, wd, fa;
        ack_delay = 1;
        do_write(16'h0011, 16'h1234, st, wr, wa, wd);
        total++; if (!wr || wa !== 16'h0011 || wd !== 16'h1234) begin bad++; $display("FAIL wr_hit_bus: got req=%b addr=%h data=%h required 1 0011 1234", wr, wa, wd); end
        total++; if (st != 2) begin bad++; $display("FAIL wr_hit_stall: got %0d required 2", st); end
        do_read(16'h0011, 16'h1234, st, rd, fa);
        total++; if (st != 0 || rd) begin bad++; $display("FAIL wr_hit_readback: got stall=%0d memread=%b required 0 0", st, rd); end
        total++; if (hit_count !== 16'd3 || miss_count !== 16'd1) begin bad++; $display("FAIL wr_hit_counters: got hit=%0d miss=%0d required 3 1", hit_count, miss_count); end
    endtask

    task automatic test_write_miss();
        int st; bit wr; bit rd; logic [15:0] wa, wd, fa;
        ack_delay = 0;
        do_write(16'h0040, 16'h5A5A, st, wr, wa, wd);
        total++; if (!wr || wa !== 16'h0040 || wd !== 16'h5A5A || st != 1) begin bad++; $display("FAIL wr_miss_bus: got req=%b addr=%h data=%h stall=%0d required 1 0040 5a5a 1", wr, wa, wd, st); end
        do_read(16'h0040, 16'h5A5A, st, rd, fa);
        total++; if (!rd || fa !== 16'h0040 || st != 2) begin bad++; $display("FAIL wr_miss_noalloc: got req=%b addr=%h stall=%0d required 1 0040 2", rd, fa, st); end
        total++; if (miss_count !== 16'd2 || hit_count !== 16'd3) begin bad++; $display("FAIL wr_miss_counters: got hit=%0d miss=%0d required 3 2", hit_count, miss_count); end
    endtask

    task automatic test_conflict();
        int st; bit rd; logic [15:0] fa;
        logic [15:0] addrs [3];
        logic [15:0] bases [3];
        addrs = '{16'h0013, 16'h0113, 16'h0013};
        bases = '{16'h0010, 16'h0110, 16'h0010};
        ack_delay = 2;
        for (int i = 0; i < 3; i++) begin
            do_read(addrs[i], pat(addrs[i]), st, rd, fa);
            total++; if (!rd || fa !== bases[i] || st != 4) begin bad++; $display("FAIL conflict_%0d: got req=%b addr=%h stall=%0d required 1 %h 4", i, rd, fa, st, bases[i]); end
        end
        total++; if (miss_count !== 16'd5 || hit_count !== 16'd3) begin bad++; $display("FAIL conflict_counters: got hit=%0d miss=%0d required 3 5", hit_count, miss_count); end
    endtask

    task automatic test_reset_mid_fill();
        int st; bit rd; logic [15:0] fa;
        resp_en = 1'b0;
        bus.cpu_read = 1'b1; bus.cpu_address = 16'h0123;
        @(negedge clk); @(negedge clk);
        total++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h0120) begin bad++; $display("FAIL abort_fill_req: got rd=%b addr=%h required 1 0120", bus.mem_read, bus.mem_address); end
        @(posedge clk); #1;
        reset_n = 1'b1; bus.cpu_read = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0; manual_ack = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        total++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL abort_memread: got %b required 0", bus.mem_read); end
        total++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin bad++; $display("FAIL abort_counters: got hit=%0d miss=%0d required 0 0", hit_count, miss_count); end
        @(posedge clk); #1;
        manual_ack = 1'b0;
        @(negedge clk);
        total++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL stray_ack: got rd=%b wr=%b ready=%b required 0 0 0", bus.mem_read, bus.mem_write, bus.cpu_ready); end
        @(posedge clk); #1;
        resp_en = 1'b1; ack_delay = 1;
        do_read(16'h0123, pat(16'h0123), st, rd, fa);
        total++; if (!rd || fa !== 16'h0120 || st != 3) begin bad++; $display("FAIL abort_remiss: got req=%b addr=%h stall=%0d required 1 0120 3", rd, fa, st); end
        total++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin bad++; $display("FAIL abort_recount: got hit=%0d miss=%0d required 0 1", hit_count, miss_count); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) model[i] = pat(16'(i));
        test_reset();
        test_read_miss();
        test_read_hits();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_fill();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d loads never completed, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache. It sits between the pipelined CPU's data-memory port (MEM stage: read_m2 / write_m2 / address2 / data) and the slower backing data memory. It holds the CPU in MEM via `cpu_ready` on misses and on writes. It also keeps hit and miss counters for the lab report.

## Interface
Parameters
- `WORD_SIZE`, 16, data and address width (word-addressed).
- `INDEX_BITS`, 2, line index width; 4 lines.
- `OFFSET_BITS`, 2, word-in-line offset width; 4 words per line.

Ports
- `clk`  in  1  single clock; all state changes on posedge.
- `reset_n`  in  1  synchronous, active-high reset (asserted = 1; the name is kept for codebase consistency).
- `cpu_read`  in  1  CPU load request; held until `cpu_ready`.
- `cpu_write`  in  1  CPU store request; held until `cpu_ready`.
- `cpu_address`  in  WORD_SIZE  word address.
- `cpu_wdata`  in  WORD_SIZE  store data.
- `cpu_rdata`  out  WORD_SIZE  load data; valid when `cpu_ready` & `cpu_read`.
- `cpu_ready`  out  1  request completes at this posedge.
- `mem_read`  out  1  line-fill request.
- `mem_write`  out  1  single-word write-through request.
- `mem_address`  out  WORD_SIZE  line base (offset zeroed) for a fill; full word address for a write.
- `mem_wdata`  out  WORD_SIZE  write-through data.
- `mem_rdata`  in  WORD_SIZE*4  fill line; word i is at bits [16i+15:16i]. Valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle pulse; the current memory request completes.
- `hit_count`  out  WORD_SIZE  load hits.
- `miss_count`  out  WORD_SIZE  load misses.

## Operation
- Address split: offset = [1:0], index = [3:2], tag = [15:4].
- Per line: valid bit, 12-bit tag, 4 data words.
- Hit = valid[index] & (tag[index] == addr tag).
- FSM states:
  - IDLE. No request: `cpu_ready`=0, no memory request. Read hit: `cpu_ready`=1 and `cpu_rdata` = cached word, combinationally in the same cycle. Read miss: `cpu_ready`=0, go to FILL. Write (hit or miss): `cpu_ready`=0, go to WRITE.
  - FILL. `mem_read`=1 and `mem_address`={tag,index,2'b00}, both held until `mem_ack`. On `mem_ack` edge: store `mem_rdata`, set tag, set valid=1, go to IDLE. The CPU's still-held read then hits.
  - WRITE. `mem_write`=1, `mem_address`=`cpu_address`, `mem_wdata`=`cpu_wdata`. `cpu_ready`=`mem_ack`. On `mem_ack` edge: if hit, update the cached word; on a miss no line is allocated. Go to IDLE.
- `cpu_read` and `cpu_write` both high: the write takes priority; the read is ignored.
- Counters, 16-bit, wrapping FFFF→0000:
  - `miss_count` increments on the IDLE→FILL transition.
  - `hit_count` increments on a read hit in IDLE, except the first IDLE cycle after a FILL. A `filled` flag suppresses that cycle so the refill completion is not also counted as a hit.
  - Writes touch neither counter.
- Address or data changes from the CPU while `cpu_ready`=0 are illegal. The cache latches nothing except the fill line.

## Timing
- Reset (sampled at posedge with `reset_n`=1):
  - state = IDLE, all valid = 0, `filled` = 0, counters = 0.
  - `mem_read`, `mem_write`, `cpu_ready` = 0 from the next cycle.
  - `cpu_rdata`, `mem_address`, `mem_wdata` = 0.
  - Reset during FILL or WRITE aborts the request. A `mem_ack` arriving afterwards is ignored in IDLE.
- Read hit: 0 extra cycles; completes in the request cycle.
- Read miss, memory acking at cycle k after FILL entry (k ≥ 0):
  - request cycle c0: miss.
  - c1..c1+k: FILL.
  - c2+k: IDLE hit, `cpu_ready`=1.
  - CPU stall = k+2 cycles.
- Write: request cycle c0; WRITE from c1; completes on the `mem_ack` cycle. Stall = k+1 cycles.
- `mem_ack` outside FILL/WRITE has no effect.
- Data tags are never prefetched; there is no replacement choice (direct-mapped overwrite).

## Test plan
- Reset, then read 0x0013 with memory acking 3 cycles after `mem_read`. Required: `mem_address`=0x0010, stall 5 cycles, `cpu_rdata`=word 3 of the fill line, `miss_count`=1, `hit_count`=0.
- Immediately read 0x0011, then 0x0012. Required: both return in the request cycle with the filled words, `hit_count`=2, no `mem_read`.
- Write 0x1234 to 0x0011 (hit), then read 0x0011. Required: `mem_write` with address 0x0011 and data 0x1234; the read returns 0x1234 as a hit.
- Write to 0x0040 (miss), then read 0x0040. Required: write-through only; the read misses (no allocate), `miss_count` +1.
- Read 0x0013, then 0x0113 (same index, different tag), then 0x0013. Required: three misses, each refilling line 0.
- Assert `reset_n`=1 mid-FILL, then pulse `mem_ack`. Required: `mem_read`=0 the next cycle, a later read of the same address misses, counters = 0.
